// File: rtl/snn_sched_pkg.sv
// Shared types and elaboration helpers for the SNN timestep scheduler.
package snn_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_EVAL,
    S_ACCUM,
    S_NEXT
  } state_e;

  // Number of pattern memory words needed to cover all input spikes.
  function automatic int num_batches(input int n_inputs, input int per_batch);
    return (n_inputs + per_batch - 1) / per_batch;
  endfunction

  // Width of a counter that must hold 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/snn_batch_assembler.sv
// Collects pattern memory words into the flat input spike vector.
// Read data arrives one cycle after the strobe, so the strobe and batch index
// are delayed one cycle and used to steer the returning word into its slice.
module snn_batch_assembler
  import snn_sched_pkg::*;
#(
  parameter int NUM_INPUTS       = 784,
  parameter int SPIKES_PER_BATCH = 32,
  parameter int BATCH_ADDR_W     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        rd_en,
  input  logic [BATCH_ADDR_W-1:0]     batch,
  input  logic [SPIKES_PER_BATCH-1:0] rd_data,
  output logic [NUM_INPUTS-1:0]       in_spikes
);

  localparam int NB = num_batches(NUM_INPUTS, SPIKES_PER_BATCH);

  logic                    vld_q, vld_d;
  logic [BATCH_ADDR_W-1:0] bsel_q, bsel_d;

  // Delay the read strobe/batch to line up with the returning data.
  always_comb begin
    vld_d  = rd_en;
    bsel_d = batch;
  end

  // Read-tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      bsel_q <= '0;
    end else begin
      vld_q  <= vld_d;
      bsel_q <= bsel_d;
    end
  end

  // One register slice per batch; the last slice is trimmed so bits past
  // NUM_INPUTS are never stored.
  for (genvar b = 0; b < NB; b++) begin : g_word
    localparam int LO = b * SPIKES_PER_BATCH;
    localparam int W  = (NUM_INPUTS - LO < SPIKES_PER_BATCH) ? (NUM_INPUTS - LO) : SPIKES_PER_BATCH;

    logic [W-1:0] word_q, word_d;

    // Clear on fetch entry, otherwise capture the word addressed to this slice.
    always_comb begin
      word_d = word_q;
      if (clear) begin
        word_d = '0;
      end else if (vld_q && (bsel_q == BATCH_ADDR_W'(b))) begin
        word_d = rd_data[W-1:0];
      end
    end

    // Slice storage.
    always_ff @(posedge clk) begin
      if (rst) word_q <= '0;
      else     word_q <= word_d;
    end

    assign in_spikes[LO +: W] = word_q;
  end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Sequences one SNN inference run: clear counters, then per timestep fetch the
// input pattern, run one network update and accumulate output spike counts.
// Optional feature: define SNN_SCHED_ABORT_EN to add an abort input that
// returns any active run to IDLE on the next edge.
module snn_timestep_scheduler
  import snn_sched_pkg::*;
#(
  parameter int NUM_INPUTS         = 784,
  parameter int SPIKES_PER_BATCH   = 32,
  parameter int BATCH_ADDR_W       = 6,
  parameter int NUM_OUTPUTS        = 100,
  parameter int OUT_ADDR_W         = 7,
  parameter int MAX_TIMESTEPS_BITS = 7
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef SNN_SCHED_ABORT_EN
  input  logic                          abort,
`endif
  input  logic                          start,
  input  logic [MAX_TIMESTEPS_BITS-1:0] sim_time,
  output logic                          busy,
  output logic                          pat_rd_en,
  output logic [BATCH_ADDR_W-1:0]       pat_batch,
  output logic [MAX_TIMESTEPS_BITS-1:0] pat_addr,
  input  logic [SPIKES_PER_BATCH-1:0]   pat_rd_data,
  output logic [NUM_INPUTS-1:0]         in_spikes,
  output logic                          net_start,
  input  logic                          net_done,
  input  logic [NUM_OUTPUTS-1:0]        out_spikes,
  output logic                          cnt_rd_en,
  output logic                          cnt_wr_en,
  output logic [OUT_ADDR_W-1:0]         cnt_addr,
  output logic [MAX_TIMESTEPS_BITS-1:0] cnt_wr_data,
  input  logic [MAX_TIMESTEPS_BITS-1:0] cnt_rd_data
);

  localparam int                    NB     = num_batches(NUM_INPUTS, SPIKES_PER_BATCH);
  localparam int                    B_W    = cnt_w(NB);
  localparam logic [B_W-1:0]        B_END  = B_W'(NB);
  localparam logic [OUT_ADDR_W-1:0] LAST_K = OUT_ADDR_W'(NUM_OUTPUTS - 1);

  state_e                          state_q, state_d;
  logic [MAX_TIMESTEPS_BITS-1:0]   sim_time_q, sim_time_d;
  logic [MAX_TIMESTEPS_BITS-1:0]   t_q, t_d;
  logic [OUT_ADDR_W-1:0]           k_q, k_d;    // neuron index in CLR/ACCUM
  logic                            ph_q, ph_d;  // sub-phase: CLR settle, EVAL started, ACCUM write
  logic [B_W-1:0]                  b_q, b_d;    // batch index in FETCH
  logic [NUM_OUTPUTS-1:0]          spk_q, spk_d;
  logic                            asm_clear;

  // Next-state and bookkeeping for the run sequencer.
  always_comb begin
    state_d    = state_q;
    sim_time_d = sim_time_q;
    t_d        = t_q;
    k_d        = k_q;
    ph_d       = ph_q;
    b_d        = b_q;
    spk_d      = spk_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLR;
          sim_time_d = sim_time;
          t_d        = '0;
          k_d        = '0;
          ph_d       = 1'b0;
        end
      end
      S_CLR: begin
        // One write per neuron, then a turnaround cycle before fetch/exit.
        if (!ph_q) begin
          if (k_q == LAST_K) ph_d = 1'b1;
          else               k_d  = k_q + 1'b1;
        end else begin
          ph_d    = 1'b0;
          k_d     = '0;
          b_d     = '0;
          state_d = (sim_time_q == '0) ? S_IDLE : S_FETCH;
        end
      end
      S_FETCH: begin
        // Reads for batches 0..NB-1, plus one cycle for the last word to land.
        if (b_q == B_END) begin
          state_d = S_EVAL;
          ph_d    = 1'b0;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      S_EVAL: begin
        ph_d = 1'b1;
        if (net_done) begin
          spk_d   = out_spikes;
          state_d = S_ACCUM;
          ph_d    = 1'b0;
          k_d     = '0;
        end
      end
      S_ACCUM: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (k_q == LAST_K) begin
            k_d     = '0;
            state_d = S_NEXT;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_NEXT: begin
        t_d     = t_q + 1'b1;
        b_d     = '0;
        state_d = (t_d == sim_time_q) ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SNN_SCHED_ABORT_EN
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ph_d    = 1'b0;
      k_d     = '0;
      b_d     = '0;
    end
`endif
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sim_time_q <= '0;
      t_q        <= '0;
      k_q        <= '0;
      ph_q       <= 1'b0;
      b_q        <= '0;
      spk_q      <= '0;
    end else begin
      state_q    <= state_d;
      sim_time_q <= sim_time_d;
      t_q        <= t_d;
      k_q        <= k_d;
      ph_q       <= ph_d;
      b_q        <= b_d;
      spk_q      <= spk_d;
    end
  end

  // Memory strobes and network handshake decoded from the current state;
  // reads and writes of the counter memory fall in different ACCUM phases.
  always_comb begin
    busy        = (state_q != S_IDLE);
    pat_rd_en   = 1'b0;
    pat_batch   = '0;
    pat_addr    = '0;
    net_start   = 1'b0;
    cnt_rd_en   = 1'b0;
    cnt_wr_en   = 1'b0;
    cnt_addr    = '0;
    cnt_wr_data = '0;
    case (state_q)
      S_CLR: begin
        if (!ph_q) begin
          cnt_wr_en = 1'b1;
          cnt_addr  = k_q;
        end
      end
      S_FETCH: begin
        if (b_q != B_END) begin
          pat_rd_en = 1'b1;
          pat_batch = BATCH_ADDR_W'(b_q);
          pat_addr  = t_q;
        end
      end
      S_EVAL: net_start = !ph_q;
      S_ACCUM: begin
        if (!ph_q) begin
          cnt_rd_en = 1'b1;
          cnt_addr  = k_q;
        end else if (spk_q[k_q]) begin
          cnt_wr_en   = 1'b1;
          cnt_addr    = k_q;
          cnt_wr_data = (&cnt_rd_data) ? cnt_rd_data : cnt_rd_data + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign asm_clear = (state_d == S_FETCH) && (state_q != S_FETCH);

  snn_batch_assembler #(
    .NUM_INPUTS      (NUM_INPUTS),
    .SPIKES_PER_BATCH(SPIKES_PER_BATCH),
    .BATCH_ADDR_W    (BATCH_ADDR_W)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (asm_clear),
    .rd_en    (pat_rd_en),
    .batch    (pat_batch),
    .rd_data  (pat_rd_data),
    .in_spikes(in_spikes)
  );

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench for snn_timestep_scheduler with pattern/counter memory and
// network models (64 inputs, 2 batches, 4 outputs, 4-bit timesteps).
module tb_snn_timestep_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  sim_time;
  logic        busy;
  logic        pat_rd_en;
  logic [0:0]  pat_batch;
  logic [3:0]  pat_addr;
  logic [31:0] pat_rd_data;
  logic [63:0] in_spikes;
  logic        net_start;
  logic        net_done;
  logic [3:0]  out_spikes;
  logic        cnt_rd_en;
  logic        cnt_wr_en;
  logic [1:0]  cnt_addr;
  logic [3:0]  cnt_wr_data;
  logic [3:0]  cnt_rd_data;
`ifdef SNN_SCHED_ABORT_EN
  logic        abort;
`endif

  snn_timestep_scheduler #(
    .NUM_INPUTS(64), .SPIKES_PER_BATCH(32), .BATCH_ADDR_W(1),
    .NUM_OUTPUTS(4), .OUT_ADDR_W(2), .MAX_TIMESTEPS_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef SNN_SCHED_ABORT_EN
    .abort(abort),
`endif
    .start(start), .sim_time(sim_time), .busy(busy),
    .pat_rd_en(pat_rd_en), .pat_batch(pat_batch), .pat_addr(pat_addr), .pat_rd_data(pat_rd_data),
    .in_spikes(in_spikes), .net_start(net_start), .net_done(net_done), .out_spikes(out_spikes),
    .cnt_rd_en(cnt_rd_en), .cnt_wr_en(cnt_wr_en), .cnt_addr(cnt_addr),
    .cnt_wr_data(cnt_wr_data), .cnt_rd_data(cnt_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- models ----------------
  logic [31:0] pat_mem [2][16];
  logic [3:0]  cnt_mem [4];
  logic [63:0] ev_in [64];
  logic [63:0] ev_dn [64];
  logic        model_done = 1'b0;
  logic        force_done;
  logic [3:0]  net_spk;
  logic        fill_en, poke_en;
  logic [1:0]  poke_addr;
  logic [3:0]  poke_val;
  int          cd = 0;
  int          cyc = 0, ns_cnt = 0, wr_cnt = 0, conflicts = 0;
  int          n_chk = 0, n_fail = 0;
  int          t_start, ns0, wr0, cf0;

  assign net_done   = model_done | force_done;
  assign out_spikes = net_spk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pat_rd_en) pat_rd_data <= pat_mem[pat_batch][pat_addr];
  end

  always @(posedge clk) begin
    if (cnt_rd_en) cnt_rd_data <= cnt_mem[cnt_addr];
    if (cnt_wr_en) begin
      cnt_mem[cnt_addr] <= cnt_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (cnt_rd_en && cnt_wr_en) conflicts <= conflicts + 1;
    if (fill_en) for (int i = 0; i < 4; i++) cnt_mem[i] <= 4'h9;
    if (poke_en) cnt_mem[poke_addr] <= poke_val;
  end

  // Network: net_done 5 cycles after net_start; record in_spikes at both ends.
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (net_start) begin
      ev_in[ns_cnt % 64] <= in_spikes;
      ns_cnt <= ns_cnt + 1;
      cd <= 4;
    end else if (cd == 1) begin
      model_done <= 1'b1;
      cd <= 0;
    end else if (cd > 1) begin
      cd <= cd - 1;
    end
    if (model_done) ev_dn[(ns_cnt - 1) % 64] <= in_spikes;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic prefill();
    @(negedge clk); fill_en = 1'b1;
    @(negedge clk); fill_en = 1'b0;
  endtask

  task automatic start_run(input logic [3:0] st);
    @(negedge clk); sim_time = st; start = 1'b1;
    @(negedge clk); start = 1'b0;
    t_start = cyc; ns0 = ns_cnt; wr0 = wr_cnt; cf0 = conflicts;
  endtask

  task automatic wait_idle(output int bc);
    int guard;
    guard = 0;
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_timeout", busy, 0);
    bc = cyc - t_start;
  endtask

  task automatic check_run(input string tag, input logic [3:0] st, input logic [15:0] exp_cnt,
                           input int exp_busy, input int exp_ns, input int exp_wr);
    int bc, bad;
    wait_idle(bc);
    chk({tag, "_counters"}, {cnt_mem[3], cnt_mem[2], cnt_mem[1], cnt_mem[0]}, exp_cnt);
    chk({tag, "_busy_cycles"}, bc, exp_busy);
    chk({tag, "_net_starts"}, ns_cnt - ns0, exp_ns);
    chk({tag, "_cnt_writes"}, wr_cnt - wr0, exp_wr);
    chk({tag, "_rd_wr_conflict"}, conflicts - cf0, 0);
    bad = 0;
    for (int s = 0; s < int'(st); s++) begin
      if (ev_in[(ns0 + s) % 64] !== {pat_mem[1][s], pat_mem[0][s]}) bad++;
      if (ev_dn[(ns0 + s) % 64] !== {pat_mem[1][s], pat_mem[0][s]}) bad++;
    end
    chk({tag, "_in_spikes_steps"}, bad, 0);
  endtask

  task automatic kill_in_accum(input bit use_abort);
    int guard;
    net_spk = 4'b1111;
    start_run(4'd3);
    guard = 0;
    while (!cnt_rd_en && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_accum", cnt_rd_en, 1);
`ifdef SNN_SCHED_ABORT_EN
    if (use_abort) abort = 1'b1; else rst = 1'b1;
`else
    rst = 1'b1;
`endif
    @(negedge clk);
    rst = 1'b0;
`ifdef SNN_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    chk(use_abort ? "abort_busy" : "rst_busy", busy, 0);
    chk(use_abort ? "abort_strobes" : "rst_strobes", {pat_rd_en, net_start, cnt_rd_en, cnt_wr_en}, 0);
    chk(use_abort ? "abort_wr_data" : "rst_wr_data", cnt_wr_data, 0);
    if (!use_abort) chk("rst_in_spikes", in_spikes, 0);
    wr0 = wr_cnt;
    repeat (10) @(negedge clk);
    chk(use_abort ? "abort_no_writes" : "rst_no_writes", wr_cnt - wr0, 0);
  endtask

  typedef struct {
    logic [3:0]  st;
    logic [3:0]  spk;
    logic [15:0] exp_cnt;  // {c3,c2,c1,c0}
    int          exp_busy; // 5 + 18*st
    int          exp_ns;
    int          exp_wr;   // 4 clears + st*popcount(spk)
  } vec_t;

  vec_t vt [6];

  // ---------------- test ----------------
  initial begin
    int bc;
    int guard;
    vt[0] = '{4'd3,  4'b0101, 16'h0303, 59,  3,  10};
    vt[1] = '{4'd1,  4'b1111, 16'h1111, 23,  1,  8};
    vt[2] = '{4'd5,  4'b1010, 16'h5050, 95,  5,  14};
    vt[3] = '{4'd2,  4'b0000, 16'h0000, 41,  2,  4};
    vt[4] = '{4'd15, 4'b1000, 16'hF000, 275, 15, 19};
    vt[5] = '{4'd0,  4'b1111, 16'h0000, 5,   0,  4};

    for (int b = 0; b < 2; b++)
      for (int t = 0; t < 16; t++)
        pat_mem[b][t] = {8'(b * 16 + t), 24'hC0FFEE ^ 24'(t * 3)};
    pat_mem[0][1] = 32'hDEADBEEF;
    pat_mem[1][1] = 32'h00000001;
    for (int i = 0; i < 4; i++) cnt_mem[i] = 4'h0;

    rst = 1'b1; start = 1'b0; sim_time = '0; force_done = 1'b0; net_spk = '0;
    fill_en = 1'b0; poke_en = 1'b0; poke_addr = '0; poke_val = '0;
`ifdef SNN_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_strobes", {pat_rd_en, net_start, cnt_rd_en, cnt_wr_en}, 0);
    chk("reset_addrs", {pat_batch, pat_addr, cnt_addr}, 0);
    chk("reset_in_spikes", in_spikes, 0);
    chk("reset_wr_data", cnt_wr_data, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      net_spk = vt[v].spk;
      prefill();
      start_run(vt[v].st);
      check_run($sformatf("vec%0d", v), vt[v].st, vt[v].exp_cnt, vt[v].exp_busy, vt[v].exp_ns, vt[v].exp_wr);
      if (v == 0) chk("pattern_t1_eval2", ev_in[(ns0 + 1) % 64], 64'h00000001_DEADBEEF);
    end

    // Saturation: neuron0 forced to E mid-run, neuron1 counts all 15 steps.
    net_spk = 4'b0011;
    prefill();
    start_run(4'd15);
    guard = 0;
    while (ns_cnt < ns0 + 4 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("sat_reach_step3", ns_cnt - ns0, 4);
    poke_en = 1'b1; poke_addr = 2'd0; poke_val = 4'hE;
    @(negedge clk); poke_en = 1'b0;
    check_run("sat", 4'd15, 16'h00FF, 275, 15, 34);

    // Spurious net_done during first FETCH and start pulse during EVAL.
    net_spk = 4'b0101;
    prefill();
    start_run(4'd3);
    repeat (5) @(negedge clk);
    force_done = 1'b1;
    @(negedge clk); force_done = 1'b0;
    guard = 0;
    while (ns_cnt < ns0 + 2 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    sim_time = 4'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check_run("ignore", 4'd3, 16'h0303, 59, 3, 10);

    kill_in_accum(1'b0);
`ifdef SNN_SCHED_ABORT_EN
    kill_in_accum(1'b1);
`endif

    // Recovery after reset mid-run.
    net_spk = 4'b0110;
    prefill();
    start_run(4'd2);
    check_run("recover", 4'd2, 16'h0220, 41, 2, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
